// File: rtl/ysyx_22050598_idu_decode_queue_if.sv
// IFU -> decode queue -> ID/EX handshake bundle.
// slave = queue side, master = surrounding pipeline.
interface ysyx_22050598_idu_decode_queue_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic            flush_i;
  logic            if_valid_i;
  logic            if_ready_o;
  logic [XLEN-1:0] if_pc_i;
  logic [31:0]     if_inst_i;
  logic            id_valid_o;
  logic            id_ready_i;
  logic [XLEN-1:0] id_pc_o;
  logic [31:0]     id_inst_o;
  logic [5:0]      id_type_o;
  logic [XLEN-1:0] id_imm_o;
  logic [4:0]      id_rs1_idx_o;
  logic [4:0]      id_rs2_idx_o;
  logic [4:0]      id_rd_idx_o;
  logic            id_w_reg_en_o;
  logic            id_inst_is_rv64_o;
  logic            id_inst_is_illegal_o;
  logic [CW-1:0]   id_count_o;

  modport slave (
    input  flush_i, if_valid_i, if_pc_i, if_inst_i, id_ready_i,
    output if_ready_o, id_valid_o, id_pc_o, id_inst_o, id_type_o,
    output id_imm_o, id_rs1_idx_o, id_rs2_idx_o, id_rd_idx_o,
    output id_w_reg_en_o, id_inst_is_rv64_o, id_inst_is_illegal_o,
    output id_count_o
  );

  modport master (
    output flush_i, if_valid_i, if_pc_i, if_inst_i, id_ready_i,
    input  if_ready_o, id_valid_o, id_pc_o, id_inst_o, id_type_o,
    input  id_imm_o, id_rs1_idx_o, id_rs2_idx_o, id_rd_idx_o,
    input  id_w_reg_en_o, id_inst_is_rv64_o, id_inst_is_illegal_o,
    input  id_count_o
  );
endinterface

// File: rtl/ysyx_22050598_idu_decode_queue.sv
// Buffered decode front-end: DEPTH-entry {pc,inst} queue
// with combinational RV32I/RV64I decode of the head entry.
module ysyx_22050598_idu_decode_queue #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  ysyx_22050598_idu_decode_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam bit IS32 = (XLEN == 32);

  logic [XLEN-1:0] r_pc   [DEPTH];
  logic [31:0]     r_inst [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [CW-1:0]   r_cnt;

  logic w_ready;
  logic w_valid;
  logic w_push;
  logic w_pop;

  assign w_ready = (r_cnt != CW'(DEPTH));
  assign w_valid = (r_cnt != '0);
  assign w_push  = bus.if_valid_i & w_ready & ~bus.flush_i;
  assign w_pop   = w_valid & bus.id_ready_i & ~bus.flush_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (bus.flush_i) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: unread slots are never exposed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wr]   <= bus.if_pc_i;
      r_inst[r_wr] <= bus.if_inst_i;
    end
  end

  logic [XLEN-1:0] w_pc;
  logic [31:0]     w_inst;
  logic [6:0]      w_opc;
  logic [2:0]      w_f3;

  assign w_pc   = r_pc[r_rd];
  assign w_inst = r_inst[r_rd];
  assign w_opc  = w_inst[6:0];
  assign w_f3   = w_inst[14:12];

  logic w_r, w_i, w_s, w_b, w_u, w_j;
  logic w_wop, w_load, w_opimm, w_opimmw, w_sh;
  logic w_known, w_ill, w_wen, w_rv64;

  assign w_r = (w_opc == 7'b0110011) | (w_opc == 7'b0111011);
  assign w_i = (w_opc == 7'b0010011) | (w_opc == 7'b0011011)
             | (w_opc == 7'b1100111) | (w_opc == 7'b0000011)
             | (w_opc == 7'b1110011);
  assign w_s = (w_opc == 7'b0100011);
  assign w_b = (w_opc == 7'b1100011);
  assign w_u = (w_opc == 7'b0110111) | (w_opc == 7'b0010111);
  assign w_j = (w_opc == 7'b1101111);

  assign w_known  = w_r | w_i | w_s | w_b | w_u | w_j;
  assign w_wop    = (w_opc == 7'b0111011) | (w_opc == 7'b0011011);
  assign w_load   = (w_opc == 7'b0000011);
  assign w_opimm  = (w_opc == 7'b0010011);
  assign w_opimmw = (w_opc == 7'b0011011);
  assign w_sh     = (w_f3 == 3'b001) | (w_f3 == 3'b101);

  // shamt[5] only exists for RV64 non-W shifts.
  assign w_ill = ~w_known
    | (IS32 & (w_wop
        | (w_load & ((w_f3 == 3'b011) | (w_f3 == 3'b110)))
        | (w_s & (w_f3 == 3'b011))
        | (w_opimm & w_sh & w_inst[25])))
    | (w_opimmw & w_sh & w_inst[25])
    | ((w_opc == 7'b1100111) & (w_f3 != 3'b000));

  assign w_wen  = (w_r | w_i | w_u | w_j) & ~w_ill
                & (w_inst[11:7] != 5'd0);
  assign w_rv64 = w_wop & ~w_ill;

  logic [31:0] w_imm32;

  always_comb begin
    w_imm32 = '0;
    if (!w_ill) begin
      unique case (1'b1)
        w_i: w_imm32 = {{20{w_inst[31]}}, w_inst[31:20]};
        w_s: w_imm32 = {{20{w_inst[31]}}, w_inst[31:25],
                        w_inst[11:7]};
        w_b: w_imm32 = {{19{w_inst[31]}}, w_inst[31], w_inst[7],
                        w_inst[30:25], w_inst[11:8], 1'b0};
        w_u: w_imm32 = {w_inst[31:12], 12'b0};
        w_j: w_imm32 = {{11{w_inst[31]}}, w_inst[31],
                        w_inst[19:12], w_inst[20],
                        w_inst[30:21], 1'b0};
        default: w_imm32 = '0;
      endcase
    end
  end

  logic [XLEN-1:0] w_imm;
  assign w_imm = XLEN'($signed(w_imm32));

  assign bus.if_ready_o = w_ready;
  assign bus.id_valid_o = w_valid;
  assign bus.id_count_o = r_cnt;

  assign bus.id_pc_o      = w_valid ? w_pc : '0;
  assign bus.id_inst_o    = w_valid ? w_inst : '0;
  assign bus.id_type_o    = w_valid ? {w_r, w_i, w_s, w_b, w_u, w_j}
                                    : '0;
  assign bus.id_imm_o     = w_valid ? w_imm : '0;
  assign bus.id_rs1_idx_o = w_valid ? w_inst[19:15] : '0;
  assign bus.id_rs2_idx_o = w_valid ? w_inst[24:20] : '0;
  assign bus.id_rd_idx_o  = w_valid ? w_inst[11:7] : '0;

  assign bus.id_w_reg_en_o        = w_valid & w_wen;
  assign bus.id_inst_is_rv64_o    = w_valid & w_rv64;
  assign bus.id_inst_is_illegal_o = w_valid & w_ill;
endmodule

// File: tb/tb_ysyx_22050598_idu_decode_queue.sv
// Directed bench: queue flow control on an RV64 instance,
// decode checks on RV64 and RV32 instances side by side.
module tb_ysyx_22050598_idu_decode_queue;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  ysyx_22050598_idu_decode_queue_if #(.XLEN(64), .DEPTH(4)) b64 ();
  ysyx_22050598_idu_decode_queue_if #(.XLEN(32), .DEPTH(4)) b32 ();

  ysyx_22050598_idu_decode_queue #(.XLEN(64), .DEPTH(4)) u_d64 (
    .clk (clk),
    .rst (rst),
    .bus (b64.slave)
  );

  ysyx_22050598_idu_decode_queue #(.XLEN(32), .DEPTH(4)) u_d32 (
    .clk (clk),
    .rst (rst),
    .bus (b32.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_both(input logic [63:0] pc,
                           input logic [31:0] inst);
    b64.if_valid_i = 1'b1;
    b64.if_pc_i    = pc;
    b64.if_inst_i  = inst;
    b32.if_valid_i = 1'b1;
    b32.if_pc_i    = pc[31:0];
    b32.if_inst_i  = inst;
    step();
    b64.if_valid_i = 1'b0;
    b32.if_valid_i = 1'b0;
  endtask

  task automatic pop_both();
    b64.id_ready_i = 1'b1;
    b32.id_ready_i = 1'b1;
    step();
    b64.id_ready_i = 1'b0;
    b32.id_ready_i = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    b64.flush_i = 0; b64.if_valid_i = 0; b64.id_ready_i = 0;
    b64.if_pc_i = '0; b64.if_inst_i = '0;
    b32.flush_i = 0; b32.if_valid_i = 0; b32.id_ready_i = 0;
    b32.if_pc_i = '0; b32.if_inst_i = '0;
    step();
    step();
    chk("rst_ready", 64'(b64.if_ready_o), 64'd1);
    chk("rst_valid", 64'(b64.id_valid_o), 64'd0);
    chk("rst_count", 64'(b64.id_count_o), 64'd0);
    chk("rst_imm",   b64.id_imm_o, 64'd0);
    chk("rst_pc",    b64.id_pc_o, 64'd0);
    chk("rst_wen",   64'(b64.id_w_reg_en_o), 64'd0);
    rst = 1'b0;

    // addi x1,x0,5
    b64.if_valid_i = 1'b1;
    b64.if_pc_i    = 64'h8000_0000;
    b64.if_inst_i  = 32'h0050_0093;
    step();
    b64.if_valid_i = 1'b0;
    chk("addi_valid", 64'(b64.id_valid_o), 64'd1);
    chk("addi_type",  64'(b64.id_type_o), 64'b010000);
    chk("addi_imm",   b64.id_imm_o, 64'd5);
    chk("addi_rd",    64'(b64.id_rd_idx_o), 64'd1);
    chk("addi_wen",   64'(b64.id_w_reg_en_o), 64'd1);
    chk("addi_count", 64'(b64.id_count_o), 64'd1);
    chk("addi_pc",    b64.id_pc_o, 64'h8000_0000);
    chk("addi_ill",   64'(b64.id_inst_is_illegal_o), 64'd0);
    b64.id_ready_i = 1'b1;
    step();
    b64.id_ready_i = 1'b0;
    chk("pop_count", 64'(b64.id_count_o), 64'd0);
    chk("pop_valid", 64'(b64.id_valid_o), 64'd0);

    // fill from slot 1 so the drain crosses the wrap
    for (int k = 0; k < 4; k++) begin
      b64.if_valid_i = 1'b1;
      b64.if_pc_i    = 64'h1000 + 64'(4 * k);
      b64.if_inst_i  = 32'h0000_0013 | (32'(k + 1) << 7);
      step();
      chk("fill_count", 64'(b64.id_count_o), 64'(k + 1));
    end
    chk("full_ready", 64'(b64.if_ready_o), 64'd0);
    b64.if_pc_i = 64'h2000;
    step();
    b64.if_valid_i = 1'b0;
    chk("full_reject_count", 64'(b64.id_count_o), 64'd4);
    chk("full_head", b64.id_pc_o, 64'h1000);

    b64.id_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_pc", b64.id_pc_o, 64'h1000 + 64'(4 * k));
      chk("drain_rd", 64'(b64.id_rd_idx_o), 64'(k + 1));
      step();
    end
    b64.id_ready_i = 1'b0;
    chk("drain_count", 64'(b64.id_count_o), 64'd0);
    chk("drain_valid", 64'(b64.id_valid_o), 64'd0);

    for (int k = 0; k < 4; k++) begin
      b64.if_valid_i = 1'b1;
      b64.if_pc_i    = 64'h3000 + 64'(4 * k);
      b64.if_inst_i  = 32'h0000_0013;
      step();
    end
    b64.if_pc_i    = 64'h3100;
    b64.id_ready_i = 1'b1;
    step();
    chk("fullpp_count", 64'(b64.id_count_o), 64'd3);
    chk("fullpp_head",  b64.id_pc_o, 64'h3004);
    b64.if_pc_i = 64'h3200;
    step();
    chk("pp_count", 64'(b64.id_count_o), 64'd3);
    chk("pp_head",  b64.id_pc_o, 64'h3008);

    b64.id_ready_i = 1'b0;
    b64.if_pc_i    = 64'h3300;
    b64.flush_i    = 1'b1;
    step();
    b64.flush_i    = 1'b0;
    b64.if_valid_i = 1'b0;
    chk("flush_count", 64'(b64.id_count_o), 64'd0);
    chk("flush_valid", 64'(b64.id_valid_o), 64'd0);
    chk("flush_ready", 64'(b64.if_ready_o), 64'd1);
    chk("flush_pc",    b64.id_pc_o, 64'd0);
    b64.if_valid_i = 1'b1;
    b64.if_pc_i    = 64'h3400;
    step();
    b64.if_valid_i = 1'b0;
    chk("postflush_count", 64'(b64.id_count_o), 64'd1);
    chk("postflush_head",  b64.id_pc_o, 64'h3400);
    b64.id_ready_i = 1'b1;
    step();
    b64.id_ready_i = 1'b0;

    // addw
    push_both(64'h4000, 32'h0010_80BB);
    chk("addw32_ill",  64'(b32.id_inst_is_illegal_o), 64'd1);
    chk("addw32_rv64", 64'(b32.id_inst_is_rv64_o), 64'd0);
    chk("addw32_wen",  64'(b32.id_w_reg_en_o), 64'd0);
    chk("addw64_ill",  64'(b64.id_inst_is_illegal_o), 64'd0);
    chk("addw64_rv64", 64'(b64.id_inst_is_rv64_o), 64'd1);
    chk("addw64_type", 64'(b64.id_type_o), 64'b100000);
    chk("addw64_wen",  64'(b64.id_w_reg_en_o), 64'd1);
    chk("addw64_imm",  b64.id_imm_o, 64'd0);
    pop_both();

    // beq x0,x0,-4
    push_both(64'h4004, 32'hFE00_0EE3);
    chk("beq_type", 64'(b64.id_type_o), 64'b000100);
    chk("beq_imm",  b64.id_imm_o, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_wen",  64'(b64.id_w_reg_en_o), 64'd0);
    pop_both();

    // lui x1,0xFFFFF
    push_both(64'h4008, 32'hFFFF_F0B7);
    chk("lui_type",  64'(b64.id_type_o), 64'b000010);
    chk("lui_imm",   b64.id_imm_o, 64'hFFFF_FFFF_FFFF_F000);
    chk("lui32_imm", 64'(b32.id_imm_o), 64'h0000_0000_FFFF_F000);
    chk("lui_wen",   64'(b64.id_w_reg_en_o), 64'd1);
    pop_both();

    push_both(64'h400C, 32'h0000_007F);
    chk("unk_ill",  64'(b64.id_inst_is_illegal_o), 64'd1);
    chk("unk_type", 64'(b64.id_type_o), 64'd0);
    chk("unk_imm",  b64.id_imm_o, 64'd0);
    chk("unk_wen",  64'(b64.id_w_reg_en_o), 64'd0);
    pop_both();

    // jalr with funct3=001
    push_both(64'h4010, 32'h0000_10E7);
    chk("jalr_ill", 64'(b64.id_inst_is_illegal_o), 64'd1);
    chk("jalr_wen", 64'(b64.id_w_reg_en_o), 64'd0);
    pop_both();

    // slli x1,x1,32
    push_both(64'h4014, 32'h0200_9093);
    chk("slli64_ill", 64'(b64.id_inst_is_illegal_o), 64'd0);
    chk("slli64_imm", b64.id_imm_o, 64'd32);
    chk("slli64_rs1", 64'(b64.id_rs1_idx_o), 64'd1);
    chk("slli32_ill", 64'(b32.id_inst_is_illegal_o), 64'd1);
    pop_both();
    chk("end_count64", 64'(b64.id_count_o), 64'd0);
    chk("end_count32", 64'(b32.id_count_o), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
